// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg: shared types and helpers for the parametrised register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Widest word the byte-merge helper handles; callers resize to DATA_W.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_read_port.sv
// ============================================================================
// reg_file_read_port: one registered read port with zero-masking and
// write-first forwarding. Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   adr_i,
    input  logic [DATA_W-1:0]   mem_word_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_adr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    output logic [DATA_W-1:0]   data_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_val;

    assign w_merged = DATA_W'(merge_bytes(MAX_DATA_W'(mem_word_i),
                                          MAX_DATA_W'(wr_data_i),
                                          MAX_BE_W'(wr_be_i)));

    always_comb begin
        w_rd_val = mem_word_i;
        if (ZERO_REG && (adr_i == '0)) begin
            w_rd_val = '0;
        end else if (wr_en_i && (wr_adr_i == adr_i)) begin
            w_rd_val = w_merged;
        end
    end

    // Outputs are forced to zero for the whole sweep.
    always_comb begin
        data_d = data_q;
        if (!run_i) begin
            data_d = '0;
        end else if (rd_en_i) begin
            data_d = w_rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_param.sv
// ============================================================================
// reg_file_param: parametrised 1W/2R register file with byte enables and a
// clearing sweep after reset or on request. Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                write,
    input  logic [ADDR_W-1:0]   adr_wr,
    input  logic [DATA_W-1:0]   data_wr,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   adr_a,
    input  logic [ADDR_W-1:0]   adr_b,
    output logic [DATA_W-1:0]   data_a,
    output logic [DATA_W-1:0]   data_b,
    output logic                ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              w_run;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_word;

    assign w_run = (state_q == ST_RUN);

    // A write coinciding with a clear request is dropped.
    assign w_wr_en = w_run && write && !clear && !rst &&
                     !(ZERO_REG && (adr_wr == '0));

    assign w_wr_word = DATA_W'(merge_bytes(MAX_DATA_W'(mem_q[adr_wr]),
                                           MAX_DATA_W'(data_wr),
                                           MAX_BE_W'(byte_en)));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else if (w_wr_en) begin
            mem_q[adr_wr] <= w_wr_word;
        end
    end

    assign ready = w_run;

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .clk        (clk),
        .rst        (rst),
        .run_i      (w_run),
        .rd_en_i    (rd_en),
        .adr_i      (adr_a),
        .mem_word_i (mem_q[adr_a]),
        .wr_en_i    (w_wr_en),
        .wr_adr_i   (adr_wr),
        .wr_data_i  (data_wr),
        .wr_be_i    (byte_en),
        .data_o     (data_a)
    );

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .clk        (clk),
        .rst        (rst),
        .run_i      (w_run),
        .rd_en_i    (rd_en),
        .adr_i      (adr_b),
        .mem_word_i (mem_q[adr_b]),
        .wr_en_i    (w_wr_en),
        .wr_adr_i   (adr_wr),
        .wr_data_i  (data_wr),
        .wr_be_i    (byte_en),
        .data_o     (data_b)
    );

endmodule

`default_nettype wire

// File: tb/tb_reg_file_param.sv
// ============================================================================
// tb_reg_file_param: directed and randomized checks of reg_file_param with
// ZERO_REG set and cleared, against a behavioural model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_param;

    logic        clk;
    logic        rst, clear, write, rd_en;
    logic [3:0]  adr_wr, adr_a, adr_b, byte_en;
    logic [31:0] data_wr;
    logic [31:0] za, zb, na, nb;
    logic        zready, nready;

    int total = 0;
    int bad   = 0;

    // Model state: contents as seen by each instance, expected outputs,
    // and the number of sweep cycles still outstanding.
    logic [31:0] mz [16];
    logic [31:0] mn [16];
    logic [31:0] eza = 0, ezb = 0, ena = 0, enb = 0;
    bit          eready = 0;
    int          clear_left = 16;

    reg_file_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .write(write), .adr_wr(adr_wr),
        .data_wr(data_wr), .byte_en(byte_en), .rd_en(rd_en), .adr_a(adr_a),
        .adr_b(adr_b), .data_a(za), .data_b(zb), .ready(zready)
    );

    reg_file_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .clear(clear), .write(write), .adr_wr(adr_wr),
        .data_wr(data_wr), .byte_en(byte_en), .rd_en(rd_en), .adr_a(adr_a),
        .adr_b(adr_b), .data_a(na), .data_b(nb), .ready(nready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rdval(input bit zr, input logic [3:0] a);
        logic [31:0] v;
        if (zr && a == 4'd0) return 32'd0;
        v = zr ? mz[a] : mn[a];
        if (write && !clear && a == adr_wr) v = merge(v, data_wr, byte_en);
        return v;
    endfunction

    // Advance the model by one edge for the current inputs, then the clock.
    task automatic tick();
        if (rst) begin
            clear_left = 16; eready = 0;
            eza = 0; ezb = 0; ena = 0; enb = 0;
            for (int i = 0; i < 16; i++) begin mz[i] = 0; mn[i] = 0; end
        end else if (clear_left > 0) begin
            clear_left--;
            eready = (clear_left == 0);
            eza = 0; ezb = 0; ena = 0; enb = 0;
        end else begin
            if (rd_en) begin
                eza = rdval(1'b1, adr_a); ezb = rdval(1'b1, adr_b);
                ena = rdval(1'b0, adr_a); enb = rdval(1'b0, adr_b);
            end
            if (write && !clear) begin
                if (adr_wr != 4'd0) mz[adr_wr] = merge(mz[adr_wr], data_wr, byte_en);
                mn[adr_wr] = merge(mn[adr_wr], data_wr, byte_en);
            end
            if (clear) begin
                clear_left = 16; eready = 0;
                for (int i = 0; i < 16; i++) begin mz[i] = 0; mn[i] = 0; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clear = 0; write = 0; rd_en = 0; adr_wr = 0; data_wr = 0;
        byte_en = 0; adr_a = 0; adr_b = 0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        write = 1; adr_wr = a; data_wr = d; byte_en = be;
        tick();
        write = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; tick(); tick(); rst = 0;
        total++; if (za !== 32'd0) begin bad++; $display("FAIL reset_data_a got=%h exp=0", za); end
        total++; if (zb !== 32'd0) begin bad++; $display("FAIL reset_data_b got=%h exp=0", zb); end
        total++; if (zready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", zready); end
        for (int n = 1; n <= 16; n++) begin
            tick();
            total++; if (zready !== (n == 16)) begin bad++; $display("FAIL reset_sweep_ready cyc=%0d got=%b exp=%b", n, zready, n == 16); end
            total++; if (nready !== (n == 16)) begin bad++; $display("FAIL reset_sweep_ready_nz cyc=%0d got=%b exp=%b", n, nready, n == 16); end
        end
        rd_en = 1;
        for (int i = 0; i < 16; i++) begin
            adr_a = 4'(i); adr_b = 4'(15 - i);
            tick();
            total++; if (za !== 32'd0 || zb !== 32'd0) begin bad++; $display("FAIL reset_contents i=%0d got=%h/%h exp=0/0", i, za, zb); end
            total++; if (na !== 32'd0 || nb !== 32'd0) begin bad++; $display("FAIL reset_contents_nz i=%0d got=%h/%h exp=0/0", i, na, nb); end
        end
        set_idle();
    endtask

    task automatic test_basic();
        set_idle();
        do_write(4'd5, 32'd555, 4'hF);
        do_write(4'd3, 32'd333, 4'hF);
        rd_en = 1; adr_a = 5; adr_b = 3;
        tick();
        total++; if (za !== 32'd555) begin bad++; $display("FAIL basic_a got=%0d exp=555", za); end
        total++; if (zb !== 32'd333) begin bad++; $display("FAIL basic_b got=%0d exp=333", zb); end
        total++; if (na !== 32'd555 || nb !== 32'd333) begin bad++; $display("FAIL basic_nz got=%0d/%0d exp=555/333", na, nb); end
        set_idle();
    endtask

    task automatic test_byte_fwd();
        set_idle();
        do_write(4'd7, 32'h11223344, 4'hF);
        write = 1; adr_wr = 7; data_wr = 32'hAABBCCDD; byte_en = 4'b0101;
        rd_en = 1; adr_a = 7; adr_b = 7;
        tick();
        total++; if (za !== 32'h11BB33DD) begin bad++; $display("FAIL fwd_a got=%h exp=11bb33dd", za); end
        total++; if (zb !== 32'h11BB33DD) begin bad++; $display("FAIL fwd_b_same_adr got=%h exp=11bb33dd", zb); end
        write = 0; byte_en = 0;
        tick();
        total++; if (za !== 32'h11BB33DD) begin bad++; $display("FAIL byte_en_stored got=%h exp=11bb33dd", za); end
        do_write(4'd7, 32'h0, 4'h0);
        rd_en = 1; tick();
        total++; if (za !== 32'h11BB33DD) begin bad++; $display("FAIL byte_en_zero got=%h exp=11bb33dd", za); end
        set_idle();
    endtask

    task automatic test_zero_reg();
        set_idle();
        do_write(4'd0, 32'hFFFFFFFF, 4'hF);
        rd_en = 1; adr_a = 0; adr_b = 0;
        tick();
        total++; if (za !== 32'd0 || zb !== 32'd0) begin bad++; $display("FAIL zero_reg got=%h/%h exp=0/0", za, zb); end
        total++; if (na !== 32'hFFFFFFFF || nb !== 32'hFFFFFFFF) begin bad++; $display("FAIL zero_reg_off got=%h/%h exp=ffffffff", na, nb); end
        set_idle();
    endtask

    task automatic test_clear_collision();
        set_idle();
        do_write(4'd5, 32'd555, 4'hF);
        clear = 1; write = 1; adr_wr = 2; data_wr = 32'd9; byte_en = 4'hF;
        rd_en = 1; adr_a = 5;
        tick();
        set_idle();
        total++; if (za !== 32'd555) begin bad++; $display("FAIL clear_read got=%0d exp=555", za); end
        total++; if (zready !== 1'b0) begin bad++; $display("FAIL clear_ready_drop got=%b exp=0", zready); end
        for (int n = 1; n <= 16; n++) begin
            tick();
            total++; if (zready !== (n == 16) || za !== 32'd0) begin bad++; $display("FAIL clear_sweep cyc=%0d ready=%b data=%h exp=%b/0", n, zready, za, n == 16); end
        end
        rd_en = 1; adr_a = 2; adr_b = 5;
        tick();
        total++; if (za !== 32'd0 || zb !== 32'd0) begin bad++; $display("FAIL clear_contents got=%h/%h exp=0/0", za, zb); end
        total++; if (na !== 32'd0 || nb !== 32'd0) begin bad++; $display("FAIL clear_contents_nz got=%h/%h exp=0/0", na, nb); end
        set_idle();
    endtask

    task automatic test_reset_midsweep();
        set_idle();
        rst = 1; tick(); rst = 0;
        for (int n = 1; n <= 8; n++) tick();
        rst = 1; tick(); rst = 0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            total++; if (zready !== (n == 16)) begin bad++; $display("FAIL midsweep_ready cyc=%0d got=%b exp=%b", n, zready, n == 16); end
        end
    endtask

    task automatic test_read_hold();
        set_idle();
        do_write(4'd9, 32'h0000CAFE, 4'hF);
        rd_en = 1; adr_a = 9; tick();
        total++; if (za !== 32'h0000CAFE) begin bad++; $display("FAIL hold_load got=%h exp=0000cafe", za); end
        rd_en = 0;
        for (int n = 0; n < 4; n++) begin
            adr_a = 4'(n + 1); write = 1; adr_wr = 9; data_wr = $urandom; byte_en = 4'hF;
            tick();
            total++; if (za !== 32'h0000CAFE) begin bad++; $display("FAIL hold_keep n=%0d got=%h exp=0000cafe", n, za); end
        end
        set_idle();
    endtask

    task automatic test_random();
        set_idle();
        for (int n = 0; n < 400; n++) begin
            write   = ($urandom_range(3) != 0);
            adr_wr  = 4'($urandom_range(15));
            data_wr = $urandom;
            byte_en = 4'($urandom);
            rd_en   = ($urandom_range(4) != 0);
            adr_a   = ($urandom_range(2) == 0) ? adr_wr : 4'($urandom_range(15));
            adr_b   = ($urandom_range(2) == 0) ? adr_wr : 4'($urandom_range(15));
            clear   = ($urandom_range(63) == 0);
            tick();
            total++; if (za !== eza || zb !== ezb) begin bad++; $display("FAIL rand_z n=%0d got=%h/%h exp=%h/%h", n, za, zb, eza, ezb); end
            total++; if (na !== ena || nb !== enb) begin bad++; $display("FAIL rand_nz n=%0d got=%h/%h exp=%h/%h", n, na, nb, ena, enb); end
            total++; if (zready !== eready || nready !== eready) begin bad++; $display("FAIL rand_ready n=%0d got=%b/%b exp=%b", n, zready, nready, eready); end
        end
        set_idle();
    endtask

    initial begin
        rst = 1;
        set_idle();
        test_reset();
        test_basic();
        test_byte_fwd();
        test_zero_reg();
        test_clear_collision();
        test_reset_midsweep();
        test_read_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the 16×32 `registerFile` used by the MIPS datapath. It provides one write port with byte enables and two read ports (A, B) feeding the operand registers. Read data is registered, with write-first forwarding. A sweep state machine clears the whole array after reset or on request, so the control block no longer relies on the array's power-up contents.

## Interface

**Parameters**
- `DATA_W`, default 32: word width; must be a multiple of 8.
- `ADDR_W`, default 4: address width; depth `DEPTH = 2**ADDR_W`.
- `ZERO_REG`, default 1: when 1, entry 0 reads as 0 and ignores writes.

**Ports**
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `clear`, input, 1: soft request to re-zero the array.
- `write`, input, 1: write strobe.
- `adr_wr`, input, ADDR_W: write address.
- `data_wr`, input, DATA_W: write data.
- `byte_en`, input, DATA_W/8: per-byte write enable; bit i covers bits [8i+7:8i].
- `rd_en`, input, 1: read-port update enable (shared by A and B).
- `adr_a`, input, ADDR_W: port A read address.
- `adr_b`, input, ADDR_W: port B read address.
- `data_a`, output, DATA_W: registered port A data.
- `data_b`, output, DATA_W: registered port B data.
- `ready`, output, 1: high when the array is initialised and accepting writes.

## Operation

**FSM states:** `ST_CLEAR` and `ST_RUN`.

**Reset**
- `rst` sampled high gives state `ST_CLEAR`, sweep pointer 0, `ready` = 0, `data_a` = `data_b` = 0.
- `rst` takes priority over every other input.

**`ST_CLEAR`**
- Each cycle writes 0 to `mem[ptr]` and increments `ptr`.
- On the cycle that writes `DEPTH-1`, the next state is `ST_RUN` and `ready` goes to 1.
- `write`, `clear` and `rd_en` are ignored; `data_a`/`data_b` are held at 0.
- `rst` mid-sweep restarts the sweep from `ptr` = 0.

**`ST_RUN`, write**
- `write` = 1 updates the bytes of `mem[adr_wr]` selected by `byte_en`; other bytes are kept.
- `byte_en` = 0 means no change.
- With `ZERO_REG` = 1 and `adr_wr` = 0, the write is discarded.

**`ST_RUN`, read**
- `rd_en` = 1 loads `data_a` ← value of `mem[adr_a]` and `data_b` ← value of `mem[adr_b]`.
- Forwarding is write-first: if a same-cycle write targets the read address, the output is the byte-merged new word.
- `ZERO_REG` = 1 and address 0 gives 0.
- `rd_en` = 0 holds both outputs.
- A and B may use equal addresses; both return the same value.

**`ST_RUN`, clear**
- `clear` = 1 gives state `ST_CLEAR` and `ready` = 0 next cycle.
- A write in that same cycle is discarded.
- A read in that same cycle completes normally and returns pre-clear contents.

**Widths:** addresses are full-range; no out-of-range case exists. No arithmetic beyond the `ADDR_W`-bit sweep pointer, which stops at `DEPTH-1` and does not wrap.

## Timing

- **Clear duration:** exactly `DEPTH` cycles after the last cycle with `rst` high (or after the `clear` edge). `ready` rises on the edge that completes entry `DEPTH-1`. Default: 16 cycles.
- **Write:** visible in array state one edge after being sampled.
- **Read latency:** 1 cycle. Address sampled at edge k gives data valid after edge k, forwarding included.
- **Read-after-write:** a write at edge k is seen by a read sampled at edge k (forwarded) and at any later edge.
- **Reset values:** `data_a`/`data_b` = 0 and `ready` = 0; both stay so through `ST_CLEAR`.

## Structure

- **Package `reg_file_pkg`:**
  - state enum `{ST_CLEAR, ST_RUN}`;
  - function `merge_bytes(old, new, be)` returning the byte-merged word.
- **Sub-module `reg_file_read_port`:** instantiated twice (A, B). Takes the array word, write-port signals, `ZERO_REG` and `rd_en`; implements zero-masking, forwarding and the output register.
- **Top-level contents:** the array, the write logic, the FSM and the sweep pointer.

## Test plan

- **Reset sweep:** `rst` for 2 cycles, defaults. `ready` = 0 for exactly 16 cycles after `rst` falls, then 1. Reads of all 16 entries return 0.
- **Basic write/read:**
  - write 555 to entry 5, then 333 to entry 3, all `byte_en` = 4'hF;
  - `adr_a` = 5, `adr_b` = 3 with `rd_en` = 1;
  - next cycle `data_a` = 555, `data_b` = 333.
- **Byte enables and forwarding:**
  - entry 7 = 32'h11223344;
  - in one cycle, write 32'hAABBCCDD with `byte_en` = 4'b0101 and read `adr_a` = 7;
  - next cycle `data_a` = 32'h11BB33DD.
- **Zero register:** write 32'hFFFFFFFF to entry 0. Read `adr_a` = `adr_b` = 0 gives 0 on both. With `ZERO_REG` = 0 it gives 32'hFFFFFFFF.
- **Soft clear with collision:**
  - entry 5 = 555;
  - assert `clear` with a same-cycle write of 9 to entry 2 and a read of `adr_a` = 5;
  - `data_a` = 555 next cycle, then 0;
  - `ready` is low for 16 cycles;
  - afterwards entry 2 = 0 and entry 5 = 0.
- **Reset mid-sweep and read hold:**
  - `rst` on sweep cycle 8 restarts the count; `ready` rises 16 cycles after the new `rst` release;
  - in `ST_RUN`, `rd_en` = 0 holds `data_a` while `adr_a` changes.
